knight_move_sequencer: RTL

//   Sequences the shared knight-square scanner through all 8 knight directions for one origin square.

---
 rtl/knight_pkg.sv | 22 ++
 rtl/knight_move_sequencer_if.sv | 26 ++
 rtl/knight_move_classify.sv | 16 +
 rtl/knight_move_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/knight_pkg.sv
// Shared constants for the knight move sequencer: direction codes, piece encoding and FSM states.
// The optional KNIGHT_SEQ_PIPELINE_EN build is handled in knight_move_sequencer.sv.
package knight_pkg;

   localparam logic [2:0] UPLEFTLEFT     = 3'd0;
   localparam logic [2:0] UPUPLEFT       = 3'd1;
   localparam logic [2:0] UPUPRIGHT      = 3'd2;
   localparam logic [2:0] UPRIGHTRIGHT   = 3'd3;
   localparam logic [2:0] DOWNRIGHTRIGHT = 3'd4;
   localparam logic [2:0] DOWNDOWNRIGHT  = 3'd5;
   localparam logic [2:0] DOWNDOWNLEFT   = 3'd6;
   localparam logic [2:0] LEFTLEFTDOWN   = 3'd7;

   localparam logic [3:0] PIECE_EMPTY = 4'h0;
   localparam int         COLOR_BIT   = 3;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

endpackage

// File: rtl/knight_move_sequencer_if.sv
// Scanner bus between the knight move sequencer (master) and the shared knight-square scanner (slave).
interface knight_move_sequencer_if;

   logic [5:0] scan_pos;
   logic [2:0] scan_dir;
   logic       scan_hit;
   logic [5:0] scan_target;
   logic [3:0] scan_piece;

   modport master (
      output scan_pos,
      output scan_dir,
      input  scan_hit,
      input  scan_target,
      input  scan_piece
   );

   modport slave (
      input  scan_pos,
      input  scan_dir,
      output scan_hit,
      output scan_target,
      output scan_piece
   );

endinterface

// File: rtl/knight_move_classify.sv
// Combinational classification of one scanner response: quiet move, capture, or nothing.
module knight_move_classify
   import knight_pkg::*;
(
   input  logic       hit,
   input  logic [3:0] piece,
   input  logic       mover_color,
   output logic       is_quiet,
   output logic       is_capture
);

   // Off-board and own-colour targets fall through as neither quiet nor capture.
   assign is_quiet   = hit && (piece == PIECE_EMPTY);
   assign is_capture = hit && (piece != PIECE_EMPTY) && (piece[COLOR_BIT] != mover_color);

endmodule

// File: rtl/knight_move_sequencer.sv
// Walks the knight-square scanner through all 8 directions for one origin and builds quiet/capture masks.
// Define KNIGHT_SEQ_PIPELINE_EN for back-to-back issue with a valid shift register; default is issue-and-wait.
module knight_move_sequencer
   import knight_pkg::*;
#(
   parameter int SCAN_LAT = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [5:0]              origin,
   input  logic                    mover_color,
   knight_move_sequencer_if.master scan,
   output logic                    busy,
   output logic                    done,
   output logic [63:0]             quiet_mask,
   output logic [63:0]             capture_mask,
   output logic [3:0]              move_count
);

   logic [1:0]  state_reg, state_next;
   logic [5:0]  scan_pos_reg, scan_pos_next;
   logic [2:0]  scan_dir_reg, scan_dir_next;
   logic        color_reg, color_next;
   logic [63:0] quiet_reg, quiet_next;
   logic [63:0] capture_reg, capture_next;
   logic [3:0]  count_reg, count_next;
   logic        is_quiet, is_capture;
   logic        sample;

`ifdef KNIGHT_SEQ_PIPELINE_EN
   logic [SCAN_LAT-1:0] vld_sr_reg, vld_sr_next;
   logic [2:0]          resp_cnt_reg, resp_cnt_next;

   // A response is valid when the issue tag has travelled the full scanner latency.
   assign sample = vld_sr_reg[SCAN_LAT-1];
`else
   localparam int WCW = (SCAN_LAT > 1) ? $clog2(SCAN_LAT) : 1;
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(SCAN_LAT - 1);

   logic [WCW-1:0] wait_cnt_reg, wait_cnt_next;

   assign sample = (state_reg == WAIT) && (wait_cnt_reg == WAIT_LAST);
`endif

   knight_move_classify u_classify (
      .hit         (scan.scan_hit),
      .piece       (scan.scan_piece),
      .mover_color (color_reg),
      .is_quiet    (is_quiet),
      .is_capture  (is_capture)
   );

   always_comb begin
      state_next    = state_reg;
      scan_pos_next = scan_pos_reg;
      scan_dir_next = scan_dir_reg;
      color_next    = color_reg;
      quiet_next    = quiet_reg;
      capture_next  = capture_reg;
      count_next    = count_reg;
`ifdef KNIGHT_SEQ_PIPELINE_EN
      vld_sr_next    = vld_sr_reg;
      vld_sr_next[0] = (state_reg == ISSUE);
      for (int i = 1; i < SCAN_LAT; i++) begin
         vld_sr_next[i] = vld_sr_reg[i-1];
      end
      resp_cnt_next = sample ? resp_cnt_reg + 3'd1 : resp_cnt_reg;
`else
      wait_cnt_next = wait_cnt_reg;
`endif

      if (sample) begin
         if (is_quiet) begin
            quiet_next[scan.scan_target] = 1'b1;
            count_next = count_reg + 4'd1;
         end
         if (is_capture) begin
            capture_next[scan.scan_target] = 1'b1;
            count_next = count_reg + 4'd1;
         end
      end

      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next    = ISSUE;
               scan_pos_next = origin;
               scan_dir_next = UPLEFTLEFT;
               color_next    = mover_color;
               quiet_next    = '0;
               capture_next  = '0;
               count_next    = '0;
`ifdef KNIGHT_SEQ_PIPELINE_EN
               resp_cnt_next = '0;
`endif
            end
         end
`ifdef KNIGHT_SEQ_PIPELINE_EN
         ISSUE: begin
            if (scan_dir_reg == LEFTLEFTDOWN) begin
               state_next = WAIT;
            end else begin
               scan_dir_next = scan_dir_reg + 3'd1;
            end
         end
         WAIT: begin
            if (sample && (resp_cnt_reg == 3'd7)) begin
               state_next = DONE;
            end
         end
`else
         ISSUE: begin
            state_next    = WAIT;
            wait_cnt_next = '0;
         end
         WAIT: begin
            if (wait_cnt_reg == WAIT_LAST) begin
               // The direction register doubles as the pass counter; it stops at the last direction.
               if (scan_dir_reg == LEFTLEFTDOWN) begin
                  state_next = DONE;
               end else begin
                  state_next    = ISSUE;
                  scan_dir_next = scan_dir_reg + 3'd1;
               end
            end else begin
               wait_cnt_next = wait_cnt_reg + 1'b1;
            end
         end
`endif
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         scan_pos_reg <= '0;
         scan_dir_reg <= '0;
         color_reg    <= 1'b0;
         quiet_reg    <= '0;
         capture_reg  <= '0;
         count_reg    <= '0;
`ifdef KNIGHT_SEQ_PIPELINE_EN
         vld_sr_reg   <= '0;
         resp_cnt_reg <= '0;
`else
         wait_cnt_reg <= '0;
`endif
      end else begin
         state_reg    <= state_next;
         scan_pos_reg <= scan_pos_next;
         scan_dir_reg <= scan_dir_next;
         color_reg    <= color_next;
         quiet_reg    <= quiet_next;
         capture_reg  <= capture_next;
         count_reg    <= count_next;
`ifdef KNIGHT_SEQ_PIPELINE_EN
         vld_sr_reg   <= vld_sr_next;
         resp_cnt_reg <= resp_cnt_next;
`else
         wait_cnt_reg <= wait_cnt_next;
`endif
      end
   end

   assign scan.scan_pos = scan_pos_reg;
   assign scan.scan_dir = scan_dir_reg;
   assign busy          = (state_reg != IDLE);
   assign done          = (state_reg == DONE);
   assign quiet_mask    = quiet_reg;
   assign capture_mask  = capture_reg;
   assign move_count    = count_reg;

endmodule
